piezo_alert_sched: RTL and testbench

//  Schedules the piezo between three alert requesters (ovr_spd, batt_low, en_steer). Picks one by fixed priority.

---
 rtl/piezo_alert_sched.sv | 174 +++++++++++++++++
 tb/tb_piezo_alert_sched.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/piezo_alert_sched.sv
// Piezo alert scheduler: fixed-priority arbitration between three alert sources,
// per-source beep bursts (tone/gap/rest) and complementary square-wave drive.
module piezo_alert_sched #(
    parameter logic fast_sim = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ovr_spd,
    input  logic       batt_low,
    input  logic       en_steer,
    input  logic       mute,
    output logic       piezo,
    output logic       piezo_n,
    output logic       busy,
    output logic [1:0] active_src
);

    localparam logic [19:0] TICK_LAST = fast_sim ? 20'd63    : 20'hF_FFFF;
    localparam logic [14:0] HP_OVR    = fast_sim ? 15'd8     : 15'd12500;
    localparam logic [14:0] HP_BATT   = fast_sim ? 15'd16    : 15'd25000;
    localparam logic [14:0] HP_STEER  = fast_sim ? 15'd12    : 15'd16667;
    localparam logic [4:0]  REST_LAST = 5'd15;

    typedef enum logic [1:0] {IDLE, TONE, GAP, REST} state_t;
    typedef enum logic [1:0] {SRC_OVR = 2'd0, SRC_BATT = 2'd1, SRC_STEER = 2'd2, SRC_NONE = 2'd3} src_t;

    state_t      state;
    src_t        src_q;
    logic [19:0] presc;
    logic [4:0]  tick_cnt;
    logic [14:0] hp_cnt;
    logic [1:0]  beep_cnt;

    logic [14:0] half_m1;
    logic [4:0]  on_last;
    logic [4:0]  gap_last;
    logic [4:0]  lim;
    logic        tick_done;
    logic        state_done;
    logic        req_any;
    src_t        sel_src;
    logic [1:0]  sel_beeps;

    // Burst shape of the source currently being served
    always_comb begin
        half_m1  = HP_STEER - 15'd1;
        on_last  = 5'd3;
        gap_last = 5'd3;
        case (src_q)
            SRC_OVR: begin
                half_m1  = HP_OVR - 15'd1;
                on_last  = 5'd3;
                gap_last = 5'd3;
            end
            SRC_BATT: begin
                half_m1  = HP_BATT - 15'd1;
                on_last  = 5'd7;
                gap_last = 5'd7;
            end
            default: begin
                half_m1  = HP_STEER - 15'd1;
                on_last  = 5'd3;
                gap_last = 5'd3;
            end
        endcase
    end

    always_comb begin
        lim = REST_LAST;
        case (state)
            TONE:    lim = on_last;
            GAP:     lim = gap_last;
            default: lim = REST_LAST;
        endcase
        tick_done  = (presc == TICK_LAST);
        state_done = tick_done && (tick_cnt == lim);
    end

    always_comb begin
        req_any   = ovr_spd | batt_low | en_steer;
        sel_src   = SRC_STEER;
        sel_beeps = 2'd1;
        if (ovr_spd) begin
            sel_src   = SRC_OVR;
            sel_beeps = 2'd3;
        end else if (batt_low) begin
            sel_src   = SRC_BATT;
            sel_beeps = 2'd2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            src_q    <= SRC_NONE;
            presc    <= '0;
            tick_cnt <= '0;
            hp_cnt   <= '0;
            beep_cnt <= '0;
            piezo    <= 1'b0;
            piezo_n  <= 1'b0;
        end else if (mute || (state != IDLE && ovr_spd && src_q != SRC_OVR)) begin
            state    <= IDLE;
            src_q    <= SRC_NONE;
            presc    <= '0;
            tick_cnt <= '0;
            hp_cnt   <= '0;
            beep_cnt <= '0;
            piezo    <= 1'b0;
            piezo_n  <= 1'b0;
        end else begin
            // Prescaler default; every state change below clears it again
            if (tick_done) begin
                presc    <= '0;
                tick_cnt <= tick_cnt + 5'd1;
            end else begin
                presc <= presc + 20'd1;
            end
            case (state)
                IDLE: begin
                    presc    <= '0;
                    tick_cnt <= '0;
                    hp_cnt   <= '0;
                    if (req_any) begin
                        state    <= TONE;
                        src_q    <= sel_src;
                        beep_cnt <= sel_beeps;
                        piezo    <= 1'b1;
                        piezo_n  <= 1'b0;
                    end
                end
                TONE: begin
                    if (hp_cnt == half_m1) begin
                        hp_cnt  <= '0;
                        piezo   <= ~piezo;
                        piezo_n <= ~piezo_n;
                    end else begin
                        hp_cnt <= hp_cnt + 15'd1;
                    end
                    if (state_done) begin
                        beep_cnt <= beep_cnt - 2'd1;
                        state    <= (beep_cnt == 2'd1) ? REST : GAP;
                        presc    <= '0;
                        tick_cnt <= '0;
                        piezo    <= 1'b0;
                        piezo_n  <= 1'b0;
                    end
                end
                GAP: begin
                    if (state_done) begin
                        state    <= TONE;
                        presc    <= '0;
                        tick_cnt <= '0;
                        hp_cnt   <= '0;
                        piezo    <= 1'b1;
                        piezo_n  <= 1'b0;
                    end
                end
                default: begin
                    if (state_done) begin
                        state    <= IDLE;
                        src_q    <= SRC_NONE;
                        presc    <= '0;
                        tick_cnt <= '0;
                    end
                end
            endcase
        end
    end

    assign busy       = (state != IDLE);
    assign active_src = src_q;

endmodule

// File: tb/tb_piezo_alert_sched.sv
// Directed self-checking bench for piezo_alert_sched in fast_sim mode (tick = 64 cycles).
module tb_piezo_alert_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ovr_spd, batt_low, en_steer, mute;
    logic       piezo, piezo_n, busy;
    logic [1:0] active_src;

    int n_cmp = 0;
    int n_err = 0;

    piezo_alert_sched #(.fast_sim(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ovr_spd    (ovr_spd),
        .batt_low   (batt_low),
        .en_steer   (en_steer),
        .mute       (mute),
        .piezo      (piezo),
        .piezo_n    (piezo_n),
        .busy       (busy),
        .active_src (active_src)
    );

    always #5 clk = ~clk;

    // Expected {busy, active_src, piezo, piezo_n} t cycles after the edge that entered the first TONE
    function automatic logic [4:0] model(input int src, input int t);
        int hp, beeps, on_c, gap_c, tt;
        logic [1:0] s;
        s     = 2'(src);
        hp    = (src == 0) ? 8 : (src == 1) ? 16 : 12;
        beeps = (src == 0) ? 3 : (src == 1) ? 2 : 1;
        on_c  = ((src == 1) ? 8 : 4) * 64;
        gap_c = ((src == 1) ? 8 : 4) * 64;
        tt    = t;
        for (int b = 0; b < beeps; b++) begin
            if (tt < on_c)
                return {1'b1, s, ((tt / hp) % 2 == 0), ((tt / hp) % 2 != 0)};
            tt -= on_c;
            if (b < beeps - 1) begin
                if (tt < gap_c) return {1'b1, s, 2'b00};
                tt -= gap_c;
            end
        end
        if (tt < 1024) return {1'b1, s, 2'b00};
        return 5'b0_11_00;
    endfunction

    function automatic logic [4:0] obs();
        return {busy, active_src, piezo, piezo_n};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ovr_spd = 1'b1; batt_low = 1'b1; en_steer = 1'b1; mute = 1'b0;
        cyc(3);
        n_cmp++;
        if (obs() !== 5'b0_11_00) begin
            n_err++; $display("FAIL reset_hold got=%b want=%b", obs(), 5'b0_11_00);
        end
        ovr_spd = 1'b0; batt_low = 1'b0; en_steer = 1'b0; rst_n = 1'b1;
        cyc(2);
        n_cmp++;
        if (obs() !== 5'b0_11_00) begin
            n_err++; $display("FAIL reset_release got=%b want=%b", obs(), 5'b0_11_00);
        end
    endtask

    task automatic test_steer_chirp();
        en_steer = 1'b1;
        cyc(1);
        en_steer = 1'b0;
        for (int t = 0; t <= 1285; t++) begin
            n_cmp++;
            if (obs() !== model(2, t)) begin
                n_err++; $display("FAIL steer_chirp t=%0d got=%b want=%b", t, obs(), model(2, t));
            end
            cyc(1);
        end
    endtask

    task automatic test_ovr_burst();
        ovr_spd = 1'b1;
        cyc(1);
        for (int t = 0; t <= 2304; t++) begin
            n_cmp++;
            if (obs() !== model(0, t)) begin
                n_err++; $display("FAIL ovr_burst t=%0d got=%b want=%b", t, obs(), model(0, t));
            end
            cyc(1);
        end
        ovr_spd = 1'b0;
        for (int t = 0; t <= 2306; t++) begin
            n_cmp++;
            if (obs() !== model(0, t)) begin
                n_err++; $display("FAIL ovr_reburst t=%0d got=%b want=%b", t, obs(), model(0, t));
            end
            cyc(1);
        end
    endtask

    task automatic test_batt_priority();
        batt_low = 1'b1; en_steer = 1'b1;
        cyc(1);
        batt_low = 1'b0; en_steer = 1'b0;
        for (int t = 0; t <= 2565; t++) begin
            n_cmp++;
            if (obs() !== model(1, t)) begin
                n_err++; $display("FAIL batt_priority t=%0d got=%b want=%b", t, obs(), model(1, t));
            end
            cyc(1);
        end
    endtask

    task automatic test_back_to_back();
        batt_low = 1'b1; en_steer = 1'b1;
        cyc(1);
        batt_low = 1'b0;
        for (int t = 0; t <= 2560; t++) begin
            n_cmp++;
            if (obs() !== model(1, t)) begin
                n_err++; $display("FAIL b2b_batt t=%0d got=%b want=%b", t, obs(), model(1, t));
            end
            cyc(1);
        end
        en_steer = 1'b0;
        for (int t = 0; t <= 1282; t++) begin
            n_cmp++;
            if (obs() !== model(2, t)) begin
                n_err++; $display("FAIL b2b_steer t=%0d got=%b want=%b", t, obs(), model(2, t));
            end
            cyc(1);
        end
    endtask

    task automatic test_preempt();
        batt_low = 1'b1;
        cyc(1);
        batt_low = 1'b0;
        for (int t = 0; t < 522; t++) begin
            n_cmp++;
            if (obs() !== model(1, t)) begin
                n_err++; $display("FAIL preempt_batt t=%0d got=%b want=%b", t, obs(), model(1, t));
            end
            cyc(1);
        end
        ovr_spd = 1'b1;
        cyc(1);
        n_cmp++;
        if (obs() !== 5'b0_11_00) begin
            n_err++; $display("FAIL preempt_idle got=%b want=%b", obs(), 5'b0_11_00);
        end
        cyc(1);
        ovr_spd = 1'b0;
        for (int t = 0; t <= 2304; t++) begin
            if (t == 300) begin
                batt_low = 1'b1; en_steer = 1'b1;
            end
            n_cmp++;
            if (obs() !== model(0, t)) begin
                n_err++; $display("FAIL preempt_ovr t=%0d got=%b want=%b", t, obs(), model(0, t));
            end
            cyc(1);
        end
        n_cmp++;
        if (obs() !== 5'b1_01_10) begin
            n_err++; $display("FAIL after_ovr_batt got=%b want=%b", obs(), 5'b1_01_10);
        end
    endtask

    task automatic test_mute();
        cyc(10);
        n_cmp++;
        if (obs() !== model(1, 10)) begin
            n_err++; $display("FAIL mute_pre got=%b want=%b", obs(), model(1, 10));
        end
        mute = 1'b1; ovr_spd = 1'b1;
        for (int k = 0; k < 20; k++) begin
            cyc(1);
            n_cmp++;
            if (obs() !== 5'b0_11_00) begin
                n_err++; $display("FAIL mute_hold k=%0d got=%b want=%b", k, obs(), 5'b0_11_00);
            end
        end
        mute = 1'b0;
        cyc(1);
        batt_low = 1'b0; en_steer = 1'b0;
        for (int t = 0; t <= 40; t++) begin
            n_cmp++;
            if (obs() !== model(0, t)) begin
                n_err++; $display("FAIL unmute_ovr t=%0d got=%b want=%b", t, obs(), model(0, t));
            end
            cyc(1);
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (obs() !== 5'b0_11_00) begin
            n_err++; $display("FAIL async_reset got=%b want=%b", obs(), 5'b0_11_00);
        end
        cyc(2);
        n_cmp++;
        if (obs() !== 5'b0_11_00) begin
            n_err++; $display("FAIL reset_held got=%b want=%b", obs(), 5'b0_11_00);
        end
        ovr_spd = 1'b0; rst_n = 1'b1;
        cyc(3);
        n_cmp++;
        if (obs() !== 5'b0_11_00) begin
            n_err++; $display("FAIL no_resume got=%b want=%b", obs(), 5'b0_11_00);
        end
    endtask

    initial begin
        test_reset();
        test_steer_chirp();
        test_ovr_burst();
        test_batt_priority();
        test_back_to_back();
        test_preempt();
        test_mute();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
